mem_port_arbiter: RTL and testbench

//  Shares one unified single-port memory between the pipelined core's instruction-fetch port and its load/store port.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_timeout_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, port owners
// and a helper that sizes the timeout counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Bits needed to count from zero up to and including the limit.
  function automatic int ctrWidth(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// BUSY-cycle watchdog for the memory arbiter; only present when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_timeout_ctr #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // Fires in the cycle whose increment would reach the limit, so the owner
  // sees exactly 'limit' BUSY cycles before the abort takes effect.
  assign expired = enable && (count == (limit - CW'(1)));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and load/store ports onto one single-port memory.
// Optional abort of stuck transactions is enabled with ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  arbState_t     state, stateNext;
  owner_t        lastOwner, lastOwnerNext;
  owner_t        owner, ownerNext;
  logic          grantData;
  logic          memReqQ, memReqNext;
  logic          memWeQ, memWeNext;
  logic [AW-1:0] memAddrQ, memAddrNext;
  logic [DW-1:0] memWdataQ, memWdataNext;
  logic          iReadyQ, iReadyNext, dReadyQ, dReadyNext;
  logic          iErrQ, iErrNext, dErrQ, dErrNext;
  logic [DW-1:0] iRdataQ, iRdataNext, dRdataQ, dRdataNext;
  logic          timeoutHit;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ctrWidth(TIMEOUT_CYC);

  arb_timeout_ctr #(.CW(CW)) timeoutCtr (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_BUSY),
    .enable  ((state == ST_BUSY) && !mem_rvalid),
    .limit   (CW'(TIMEOUT_CYC)),
    .expired (timeoutHit)
  );
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYC > 0);
  assign timeoutHit       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lastOwner <= OWN_I;
      owner     <= OWN_I;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      iReadyQ   <= 1'b0;
      dReadyQ   <= 1'b0;
      iErrQ     <= 1'b0;
      dErrQ     <= 1'b0;
      iRdataQ   <= '0;
      dRdataQ   <= '0;
    end else begin
      state     <= stateNext;
      lastOwner <= lastOwnerNext;
      owner     <= ownerNext;
      memReqQ   <= memReqNext;
      memWeQ    <= memWeNext;
      memAddrQ  <= memAddrNext;
      memWdataQ <= memWdataNext;
      iReadyQ   <= iReadyNext;
      dReadyQ   <= dReadyNext;
      iErrQ     <= iErrNext;
      dErrQ     <= dErrNext;
      iRdataQ   <= iRdataNext;
      dRdataQ   <= dRdataNext;
    end
  end

  // Data wins a tie unless it also won the previous grant, which keeps
  // back-to-back loads/stores from starving instruction fetch.
  always_comb begin
    stateNext     = state;
    lastOwnerNext = lastOwner;
    ownerNext     = owner;
    grantData     = 1'b0;
    memReqNext    = memReqQ;
    memWeNext     = memWeQ;
    memAddrNext   = memAddrQ;
    memWdataNext  = memWdataQ;
    iReadyNext    = 1'b0;
    dReadyNext    = 1'b0;
    iErrNext      = 1'b0;
    dErrNext      = 1'b0;
    iRdataNext    = iRdataQ;
    dRdataNext    = dRdataQ;

    case (state)
      ST_IDLE: begin
        grantData = d_req && !(i_req && (lastOwner == OWN_D));
        if (i_req || d_req) begin
          stateNext     = ST_BUSY;
          memReqNext    = 1'b1;
          ownerNext     = grantData ? OWN_D : OWN_I;
          lastOwnerNext = ownerNext;
          memWeNext     = grantData && d_we;
          memAddrNext   = grantData ? d_addr : i_addr;
          memWdataNext  = grantData ? d_wdata : '0;
        end
      end
      ST_BUSY: begin
        if (mem_rvalid || timeoutHit) begin
          stateNext  = ST_RESP;
          memReqNext = 1'b0;
          if (owner == OWN_D) begin
            dReadyNext = 1'b1;
            dErrNext   = !mem_rvalid;
            if (!mem_rvalid) begin
              dRdataNext = '0;
            end else if (!memWeQ) begin
              dRdataNext = mem_rdata;
            end
          end else begin
            iReadyNext = 1'b1;
            iErrNext   = !mem_rvalid;
            iRdataNext = mem_rvalid ? mem_rdata : '0;
          end
        end
      end
      ST_RESP: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  assign mem_req   = memReqQ;
  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign i_ready   = iReadyQ;
  assign i_rdata   = iRdataQ;
  assign i_err     = iErrQ;
  assign d_ready   = dReadyQ;
  assign d_rdata   = dRdataQ;
  assign d_err     = dErrQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req, d_req, d_we, mem_rvalid;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_ready, i_err, d_ready, d_err, mem_req, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ready    (i_ready),
    .i_rdata    (i_rdata),
    .i_err      (i_err),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ready    (d_ready),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] memData;
    logic        expD;
    logic        expWe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expIRdata;
    logic [31:0] expDRdata;
  } vec_t;

  vec_t vecs[6];
  int   assertCount = 0;
  int   failCount = 0;

  // random-phase model state
  logic        pendI, pendD, busy, ownD, lastD, armed, freeSoon, rvDriven, gWe, winD;
  logic [31:0] gAddr, gWdata, rvData, expIR, expDR;
  int          waitCnt, highCycles;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    i_req      = 1'b0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic doReset;
    reset = 1'b0;
    idleInputs();
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // One directed transaction from IDLE with exact cycle timing.
  task automatic applyStimulus(input int idx, input vec_t v);
    i_req   = v.iReq;
    i_addr  = v.iAddr;
    d_req   = v.dReq;
    d_we    = v.dWe;
    d_addr  = v.dAddr;
    d_wdata = v.dWdata;
    tick();
    checkOutput($sformatf("vec%0d mem_req c1", idx), mem_req, 1'b1);
    checkOutput($sformatf("vec%0d mem_we", idx), mem_we, v.expWe);
    checkOutput($sformatf("vec%0d mem_addr", idx), mem_addr, v.expAddr);
    if (v.expWe) checkOutput($sformatf("vec%0d mem_wdata", idx), mem_wdata, v.expWdata);
    tick();
    checkOutput($sformatf("vec%0d mem_req c2", idx), mem_req, 1'b1);
    checkOutput($sformatf("vec%0d early ready", idx), {i_ready, d_ready}, 2'b00);
    mem_rvalid = 1'b1;
    mem_rdata  = v.memData;
    tick();
    mem_rvalid = 1'b0;
    checkOutput($sformatf("vec%0d mem_req c3", idx), mem_req, 1'b0);
    checkOutput($sformatf("vec%0d i_ready", idx), i_ready, !v.expD);
    checkOutput($sformatf("vec%0d d_ready", idx), d_ready, v.expD);
    checkOutput($sformatf("vec%0d err", idx), {i_err, d_err}, 2'b00);
    checkOutput($sformatf("vec%0d i_rdata", idx), i_rdata, v.expIRdata);
    checkOutput($sformatf("vec%0d d_rdata", idx), d_rdata, v.expDRdata);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    checkOutput($sformatf("vec%0d ready pulse", idx), {i_ready, d_ready}, 2'b00);
  endtask

  // Waits (bounded) for the next grant, checks it, completes it, checks ready.
  task automatic serveOne(input string tag, input logic expD, input logic expWe,
                          input logic [31:0] expAddr, input logic [31:0] expWdata,
                          input logic [31:0] rdata);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!mem_req && n < 6);
    checkOutput({tag, " mem_req"}, mem_req, 1'b1);
    checkOutput({tag, " mem_we"}, mem_we, expWe);
    checkOutput({tag, " mem_addr"}, mem_addr, expAddr);
    if (expWe) checkOutput({tag, " mem_wdata"}, mem_wdata, expWdata);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    checkOutput({tag, " i_ready"}, i_ready, !expD);
    checkOutput({tag, " d_ready"}, d_ready, expD);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF,
                1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678,
                1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 32'h12345678};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hA5A5, 32'hFFFF0000,
                1'b1, 1'b1, 32'h80, 32'hA5A5, 32'hDEADBEEF, 32'h12345678};
    vecs[3] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D,
                1'b0, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 32'h12345678};
    vecs[4] = '{1'b1, 32'h108, 1'b1, 1'b0, 32'h48, 32'h0, 32'h0BADCAFE,
                1'b1, 1'b0, 32'h48, 32'h0, 32'hCAFEF00D, 32'h0BADCAFE};
    vecs[5] = '{1'b1, 32'h10C, 1'b0, 1'b1, 32'h999, 32'h1, 32'h11112222,
                1'b0, 1'b0, 32'h10C, 32'h0, 32'h11112222, 32'h0BADCAFE};

    idleInputs();
    i_addr    = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;

    // reset values
    repeat (2) tick();
    checkOutput("reset mem_req", mem_req, 1'b0);
    checkOutput("reset mem_we", mem_we, 1'b0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset ready", {i_ready, d_ready}, 2'b00);
    checkOutput("reset err", {i_err, d_err}, 2'b00);
    checkOutput("reset i_rdata", i_rdata, 32'h0);
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    // tie: store wins, then the held fetch
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
    serveOne("tie store", 1'b1, 1'b1, 32'h200, 32'h55, 32'h99999999);
    d_req = 1'b0;
    checkOutput("store keeps d_rdata", d_rdata, 32'h0BADCAFE);
    serveOne("tie fetch", 1'b0, 1'b0, 32'h300, 32'h0, 32'h30303030);
    i_req = 1'b0;

    // fairness: fetch held, loads re-asserted after each d_ready
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    serveOne("fair D0", 1'b1, 1'b0, 32'h500, 32'h0, 32'hD0);
    d_addr = 32'h504;
    serveOne("fair I1", 1'b0, 1'b0, 32'h400, 32'h0, 32'hA1);
    i_addr = 32'h404;
    serveOne("fair D2", 1'b1, 1'b0, 32'h504, 32'h0, 32'hD2);
    d_addr = 32'h508;
    serveOne("fair I3", 1'b0, 1'b0, 32'h404, 32'h0, 32'hA3);
    idleInputs();
    tick();
    checkOutput("fair i_rdata", i_rdata, 32'hA3);
    checkOutput("fair d_rdata", d_rdata, 32'hD2);

    // spurious rvalid while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("spurious mem_req", mem_req, 1'b0);
      checkOutput("spurious ready", {i_ready, d_ready}, 2'b00);
    end
    mem_rvalid = 1'b0;
    checkOutput("spurious i_rdata", i_rdata, 32'hA3);
    checkOutput("spurious d_rdata", d_rdata, 32'hD2);

    // reset while a load is in BUSY
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    tick();
    checkOutput("abort grant", mem_req, 1'b1);
    d_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("abort async mem_req", mem_req, 1'b0);
    checkOutput("abort i_rdata", i_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("abort no ready", {i_ready, d_ready}, 2'b00);
    checkOutput("abort no err", {i_err, d_err}, 2'b00);
    checkOutput("abort mem_req idle", mem_req, 1'b0);
    checkOutput("abort d_rdata", d_rdata, 32'h0);
    tick();
    checkOutput("abort still no ready", {i_ready, d_ready}, 2'b00);
    // last owner back to fetch, so data wins this tie
    i_req = 1'b1; i_addr = 32'h800;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h900;
    serveOne("post-reset tie", 1'b1, 1'b0, 32'h900, 32'h0, 32'h1234);
    d_req = 1'b0;
    serveOne("post-reset fetch", 1'b0, 1'b0, 32'h800, 32'h0, 32'h5678);
    idleInputs();
    tick();

`ifdef ARB_TIMEOUT_EN
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    tick();
    for (int k = 0; k < 3; k++) begin
      checkOutput("timeout mem_req held", mem_req, 1'b1);
      tick();
    end
    checkOutput("timeout mem_req c4", mem_req, 1'b1);
    tick();
    checkOutput("timeout mem_req drop", mem_req, 1'b0);
    checkOutput("timeout d_ready", d_ready, 1'b1);
    checkOutput("timeout d_err", d_err, 1'b1);
    checkOutput("timeout d_rdata", d_rdata, 32'h0);
    checkOutput("timeout i_err", i_err, 1'b0);
    d_req = 1'b0;
    tick();
    checkOutput("timeout pulse", {d_ready, d_err}, 2'b00);
`else
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    highCycles = 0;
    repeat (120) begin
      tick();
      if (mem_req && !d_ready) highCycles++;
    end
    checkOutput("no-timeout hold", highCycles, 120);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h600D;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("no-timeout d_ready", d_ready, 1'b1);
    checkOutput("no-timeout d_err", d_err, 1'b0);
    checkOutput("no-timeout d_rdata", d_rdata, 32'h600D);
    d_req = 1'b0;
    tick();
`endif

    // randomized traffic against a transaction-level model
    doReset();
    pendI = 1'b0; pendD = 1'b0; busy = 1'b0; ownD = 1'b0; lastD = 1'b0;
    armed = 1'b1; freeSoon = 1'b0; gWe = 1'b0; gAddr = '0; gWdata = '0;
    expIR = '0; expDR = '0; waitCnt = 0; rvData = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pendI && $urandom_range(0, 2) == 0) begin
        pendI  = 1'b1;
        i_addr = $urandom;
      end
      if (!pendD && $urandom_range(0, 2) == 0) begin
        pendD   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      i_req = pendI;
      d_req = pendD;
      rvDriven = 1'b0;
      if (busy) begin
        if (waitCnt == 0) begin
          rvData     = $urandom;
          mem_rdata  = rvData;
          mem_rvalid = 1'b1;
          rvDriven   = 1'b1;
        end else begin
          waitCnt--;
          mem_rvalid = 1'b0;
        end
      end else begin
        mem_rvalid = ($urandom_range(0, 7) == 0);
        mem_rdata  = $urandom;
      end

      tick();

      if (armed && (i_req || d_req)) begin
        winD = d_req && !(i_req && lastD);
        gWe    = winD && d_we;
        gAddr  = winD ? d_addr : i_addr;
        gWdata = d_wdata;
        checkOutput("rnd grant mem_req", mem_req, 1'b1);
        checkOutput("rnd grant mem_we", mem_we, gWe);
        checkOutput("rnd grant mem_addr", mem_addr, gAddr);
        if (gWe) checkOutput("rnd grant mem_wdata", mem_wdata, gWdata);
        busy    = 1'b1;
        ownD    = winD;
        lastD   = winD;
        armed   = 1'b0;
        waitCnt = $urandom_range(0, 3);
      end else if (busy && !rvDriven) begin
        checkOutput("rnd busy mem_req", mem_req, 1'b1);
        checkOutput("rnd busy mem_addr", mem_addr, gAddr);
        checkOutput("rnd busy mem_we", mem_we, gWe);
      end else if (!busy) begin
        checkOutput("rnd idle mem_req", mem_req, 1'b0);
      end

      if (freeSoon) begin
        armed    = 1'b1;
        freeSoon = 1'b0;
      end

      if (rvDriven) begin
        busy     = 1'b0;
        freeSoon = 1'b1;
        if (ownD) begin
          if (!gWe) expDR = rvData;
          pendD = 1'b0;
        end else begin
          expIR = rvData;
          pendI = 1'b0;
        end
        checkOutput("rnd done mem_req", mem_req, 1'b0);
        checkOutput("rnd i_ready", i_ready, !ownD);
        checkOutput("rnd d_ready", d_ready, ownD);
      end else begin
        checkOutput("rnd no ready", {i_ready, d_ready}, 2'b00);
      end
      checkOutput("rnd i_rdata", i_rdata, expIR);
      checkOutput("rnd d_rdata", d_rdata, expDR);
      checkOutput("rnd err", {i_err, d_err}, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
